// File: rtl/riscv_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_run_ctrl_pkg
// Description : Shared definitions for the RISC-V run controller: FSM state
//               encodings and default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_run_ctrl_pkg;

  // Run controller FSM states, 2-bit encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Default width of the cycle counter and each per-core retire counter
  localparam int DEFAULT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/riscv_run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Clear wins over
//               enable; the count sticks at all ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import riscv_run_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_CNT_W
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count enabled cycles, holding at the maximum value
  always_ff @(posedge clock) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_run_ctrl
// Description : Run controller for unicycle RISC-V cores. Sequences the core
//               reset, counts run cycles and retired instructions, detects
//               completion from per-core finish flags and guards the run with
//               a cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_ctrl
  import riscv_run_ctrl_pkg::*;
#(
  parameter int N_CORES    = 2,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 1000,
  parameter int FINISH_ALL = 1
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_CORES-1:0]       finish_flag,
  input  logic [N_CORES-1:0]       retire,
  output logic                     core_rst,
  output logic                     run_active,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [N_CORES-1:0]       finished_mask,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [N_CORES*CNT_W-1:0] retire_count
);

  // Reset-phase counter only needs to reach RST_CYCLES-1
  localparam int              RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYCLES - 1);
  // Watchdog fires when the pre-increment cycle count equals this value
  localparam logic [31:0]     WD_LAST  = (MAX_CYCLES > 0) ? 32'(MAX_CYCLES - 1) : 32'd0;

  logic [1:0]         state;
  logic [RCW-1:0]     rst_cnt;
  logic               in_run;
  logic               clear;
  logic [N_CORES-1:0] next_mask;
  logic               complete;
  logic               wd_hit;
  logic [N_CORES-1:0] retire_en;

  // Decode run qualifiers, completion and watchdog from current state
  always_comb begin
    in_run    = (state == ST_RUN);
    clear     = start && ((state == ST_IDLE) || (state == ST_DONE));
    next_mask = finished_mask | finish_flag;
    complete  = (FINISH_ALL != 0) ? (&next_mask) : (|next_mask);
    wd_hit    = (MAX_CYCLES > 0) && (32'(cycle_count) == WD_LAST);
    // A core's retires stop counting once its finish was seen on an earlier edge
    retire_en = in_run ? (retire & ~finished_mask) : '0;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clock (clock),
    .rst   (rst),
    .clr   (clear),
    .en    (in_run),
    .q     (cycle_count)
  );

  for (genvar i = 0; i < N_CORES; i++) begin : g_retire
    sat_counter #(
      .W (CNT_W)
    ) u_retire_cnt (
      .clock (clock),
      .rst   (rst),
      .clr   (clear),
      .en    (retire_en[i]),
      .q     (retire_count[i*CNT_W +: CNT_W])
    );
  end

  // Run sequencing FSM and registered status outputs
  always_ff @(posedge clock) begin
    if (!rst) begin
      state         <= ST_IDLE;
      rst_cnt       <= '0;
      core_rst      <= 1'b1;
      run_active    <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      finished_mask <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_RESET;
            rst_cnt       <= '0;
            core_rst      <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            finished_mask <= '0;
          end
        end
        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state      <= ST_RUN;
            core_rst   <= 1'b0;
            run_active <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          finished_mask <= next_mask;
          // Completion takes priority over a simultaneous watchdog expiry
          if (complete || wd_hit) begin
            state      <= ST_DONE;
            core_rst   <= 1'b1;
            run_active <= 1'b0;
            done       <= 1'b1;
            pass       <= complete;
            timeout    <= !complete;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_run_ctrl
// Description : Self-checking bench for riscv_run_ctrl. Four instances with
//               different configurations share one stimulus stream; every
//               edge is compared against a behavioural phase model, plus
//               table-driven start timing and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_run_ctrl;

  localparam int RSTC      = 4;
  localparam int CW_P  [4] = '{16, 16, 16, 4};
  localparam int MAXC_P[4] = '{1000, 1000, 50, 0};
  localparam int FA_P  [4] = '{1, 0, 1, 1};

  logic       clock = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] finish_flag;
  logic [1:0] retire;

  logic        core_rst_v   [4];
  logic        run_active_v [4];
  logic        done_v       [4];
  logic        pass_v       [4];
  logic        timeout_v    [4];
  logic [1:0]  mask_v       [4];
  logic [15:0] cyc_v        [3];
  logic [31:0] ret_v        [3];
  logic [3:0]  cyc_d;
  logic [7:0]  ret_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    riscv_run_ctrl #(
      .N_CORES    (2),
      .CNT_W      (16),
      .RST_CYCLES (RSTC),
      .MAX_CYCLES (MAXC_P[k]),
      .FINISH_ALL (FA_P[k])
    ) u_dut (
      .clock         (clock),
      .rst           (rst),
      .start         (start),
      .finish_flag   (finish_flag),
      .retire        (retire),
      .core_rst      (core_rst_v[k]),
      .run_active    (run_active_v[k]),
      .done          (done_v[k]),
      .pass          (pass_v[k]),
      .timeout       (timeout_v[k]),
      .finished_mask (mask_v[k]),
      .cycle_count   (cyc_v[k]),
      .retire_count  (ret_v[k])
    );
  end

  riscv_run_ctrl #(
    .N_CORES    (2),
    .CNT_W      (4),
    .RST_CYCLES (RSTC),
    .MAX_CYCLES (0),
    .FINISH_ALL (1)
  ) u_dut_sat (
    .clock         (clock),
    .rst           (rst),
    .start         (start),
    .finish_flag   (finish_flag),
    .retire        (retire),
    .core_rst      (core_rst_v[3]),
    .run_active    (run_active_v[3]),
    .done          (done_v[3]),
    .pass          (pass_v[3]),
    .timeout       (timeout_v[3]),
    .finished_mask (mask_v[3]),
    .cycle_count   (cyc_d),
    .retire_count  (ret_d)
  );

  // Behavioural model: each instance is in one of four run phases
  typedef enum {M_IDLE, M_WAIT, M_RUN, M_END} phase_t;
  phase_t     m_ph   [4];
  int         m_left [4];
  int         m_cyc  [4];
  int         m_ret  [4][2];
  logic [1:0] m_mask [4];
  bit         m_pass [4];
  bit         m_to   [4];

  task automatic model_step(input int k);
    int  top;
    int  old;
    bit  fin;
    top = (1 << CW_P[k]) - 1;
    if (!rst) begin
      m_ph[k] = M_IDLE; m_cyc[k] = 0; m_ret[k][0] = 0; m_ret[k][1] = 0;
      m_mask[k] = 2'b00; m_pass[k] = 0; m_to[k] = 0; m_left[k] = 0;
    end else begin
      case (m_ph[k])
        M_IDLE, M_END: if (start) begin
          m_ph[k] = M_WAIT; m_left[k] = RSTC; m_cyc[k] = 0;
          m_ret[k][0] = 0; m_ret[k][1] = 0; m_mask[k] = 2'b00;
          m_pass[k] = 0; m_to[k] = 0;
        end
        M_WAIT: begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_ph[k] = M_RUN;
        end
        M_RUN: begin
          old = m_cyc[k];
          for (int i = 0; i < 2; i++)
            if (retire[i] && !m_mask[k][i] && m_ret[k][i] < top) m_ret[k][i]++;
          if (old < top) m_cyc[k] = old + 1;
          m_mask[k] = m_mask[k] | finish_flag;
          fin = (FA_P[k] != 0) ? (m_mask[k] == 2'b11) : (m_mask[k] != 2'b00);
          if (fin) begin
            m_ph[k] = M_END; m_pass[k] = 1; m_to[k] = 0;
          end else if (MAXC_P[k] != 0 && old == MAXC_P[k] - 1) begin
            m_ph[k] = M_END; m_pass[k] = 0; m_to[k] = 1;
          end
        end
        default: m_ph[k] = M_IDLE;
      endcase
    end
  endtask

  // {core_rst, run_active, done, pass, timeout, mask, cycle, ret0, ret1}
  function automatic logic [54:0] exp_vec(input int k);
    return {m_ph[k] != M_RUN, m_ph[k] == M_RUN, m_ph[k] == M_END, m_pass[k], m_to[k],
            m_mask[k], 16'(m_cyc[k]), 16'(m_ret[k][0]), 16'(m_ret[k][1])};
  endfunction

  function automatic logic [54:0] act_vec(input int k);
    logic [15:0] c, r0, r1;
    if (k < 3) begin
      c = cyc_v[k]; r0 = ret_v[k][15:0]; r1 = ret_v[k][31:16];
    end else begin
      c = {12'd0, cyc_d}; r0 = {12'd0, ret_d[3:0]}; r1 = {12'd0, ret_d[7:4]};
    end
    return {core_rst_v[k], run_active_v[k], done_v[k], pass_v[k], timeout_v[k], mask_v[k], c, r0, r1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare every instance
  task automatic cyc(input logic r, input logic s, input logic [1:0] ff, input logic [1:0] rt);
    @(negedge clock);
    rst = r; start = s; finish_flag = ff; retire = rt;
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      model_step(k);
      check($sformatf("model_u%0d", k), act_vec(k), exp_vec(k));
    end
  endtask

  // Reset everything, start, and wait out the reset phase: next edge is RUN cycle 1
  task automatic begin_run();
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b1, 1'b1, 2'b00, 2'b00);
    repeat (RSTC) cyc(1'b1, 1'b0, 2'b00, 2'b00);
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic        exp_core_rst;
    logic        exp_run;
    logic [15:0] exp_cyc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst = 1'b0; start = 1'b0; finish_flag = 2'b00; retire = 2'b00;

    // Start timing: reset edges 1..3, start sampled at edge 10
    for (int e = 1; e <= 16; e++) begin
      tbl[e-1].rst          = (e > 3);
      tbl[e-1].start        = (e == 10);
      tbl[e-1].exp_core_rst = (e <= 13);
      tbl[e-1].exp_run      = (e >= 14);
      tbl[e-1].exp_cyc      = (e >= 15) ? 16'(e - 14) : 16'd0;
    end
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].start, 2'b00, 2'b00);
      check($sformatf("startseq_e%0d", i + 1),
            {core_rst_v[0], run_active_v[0], done_v[0], cyc_v[0]},
            {tbl[i].exp_core_rst, tbl[i].exp_run, 1'b0, tbl[i].exp_cyc});
    end

    // All-finish completion: core0 at cycle 20, core1 at 35, 5 retires each
    begin_run();
    for (int c = 1; c <= 35; c++)
      cyc(1'b1, 1'b0, {c >= 35, c >= 20}, (c <= 5) ? 2'b11 : 2'b00);
    check("fin_all_u0", act_vec(0), {5'b10110, 2'b11, 16'd35, 16'd5, 16'd5});
    check("fin_any_u1", act_vec(1), {5'b10110, 2'b01, 16'd20, 16'd5, 16'd5});
    check("fin_all_sat_u3", act_vec(3), {5'b10110, 2'b11, 16'd15, 16'd5, 16'd5});
    cyc(1'b1, 1'b0, 2'b11, 2'b11);
    cyc(1'b1, 1'b0, 2'b11, 2'b11);
    check("done_frozen_u0", act_vec(0), {5'b10110, 2'b11, 16'd35, 16'd5, 16'd5});

    // Any-finish completion on core1 at cycle 12; start mid-run ignored
    begin_run();
    for (int c = 1; c <= 12; c++)
      cyc(1'b1, c == 5, (c == 12) ? 2'b10 : 2'b00, 2'b00);
    check("fin_any_u1_c12", act_vec(1), {5'b10110, 2'b10, 16'd12, 16'd0, 16'd0});
    check("start_ign_u0", act_vec(0), {5'b01000, 2'b10, 16'd12, 16'd0, 16'd0});

    // Mid-run reset at RUN cycle 7
    begin_run();
    for (int c = 1; c <= 6; c++) cyc(1'b1, 1'b0, 2'b00, 2'b11);
    cyc(1'b0, 1'b0, 2'b00, 2'b11);
    check("midrun_rst_u0", act_vec(0), {5'b10000, 2'b00, 16'd0, 16'd0, 16'd0});
    cyc(1'b1, 1'b0, 2'b00, 2'b11);
    check("idle_hold_u0", act_vec(0), {5'b10000, 2'b00, 16'd0, 16'd0, 16'd0});

    // Watchdog at 50 cycles, then restart and finish on the expiry edge
    begin_run();
    for (int c = 1; c <= 49; c++) cyc(1'b1, 1'b0, 2'b00, 2'b00);
    check("wd_pre_u2", act_vec(2), {5'b01000, 2'b00, 16'd49, 16'd0, 16'd0});
    cyc(1'b1, 1'b0, 2'b00, 2'b00);
    check("wd_fire_u2", act_vec(2), {5'b10101, 2'b00, 16'd50, 16'd0, 16'd0});
    for (int c = 51; c <= 55; c++) cyc(1'b1, 1'b0, 2'b00, 2'b00);
    cyc(1'b1, 1'b1, 2'b00, 2'b00);
    check("restart_to_u2", act_vec(2), {5'b10000, 2'b00, 16'd0, 16'd0, 16'd0});
    repeat (RSTC) cyc(1'b1, 1'b0, 2'b00, 2'b00);
    for (int c = 1; c <= 49; c++) cyc(1'b1, 1'b0, 2'b00, 2'b00);
    cyc(1'b1, 1'b0, 2'b11, 2'b00);
    check("wd_vs_fin_u2", act_vec(2), {5'b10110, 2'b11, 16'd50, 16'd0, 16'd0});
    cyc(1'b1, 1'b1, 2'b00, 2'b00);
    check("restart_pass_u2", act_vec(2), {5'b10000, 2'b00, 16'd0, 16'd0, 16'd0});

    // Saturation with a 4-bit counter and watchdog disabled
    begin_run();
    for (int c = 1; c <= 20; c++) cyc(1'b1, 1'b0, 2'b00, 2'b01);
    check("sat_u3", act_vec(3), {5'b01000, 2'b00, 16'd15, 16'd15, 16'd0});
    check("nosat_u0", act_vec(0), {5'b01000, 2'b00, 16'd20, 16'd20, 16'd0});

    // Randomized traffic against the phase model
    for (int n = 0; n < 1500; n++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0,
          {$urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0},
          2'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
